cclut_lookup_sched: RTL and testbench

- Time-shares the two read ports of the CCLUT pattern LUT (five pattern ROMs, dual address ports, 9-bit {offset[3:0], bend[4:0]} data) between NREQ CLCT pattern-finder requesters.
- Each cycle, a round-robin arbiter grants up to two requests and drives them onto LUT port 0 and port 1.
- It tracks the LUT read latency with a tagged pipeline and returns each result to the requester that issued it.
- Sits between the per-CFEB pattern finders and the LUT instance in the pattern_finder hierarchy.

---
 rtl/cclut_lookup_sched.sv | 266 ++++++++++++++++++++++++++
 tb/tb_cclut_lookup_sched.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cclut_lookup_sched.sv
// Round-robin scheduler that shares the two CCLUT pattern-LUT read ports among NREQ
// pattern-finder requesters and returns each tagged result after a fixed latency.
module cclut_lookup_sched #(
   parameter int unsigned NREQ      = 4,
   parameter int unsigned MXIDB     = 3,
   parameter int unsigned MXPATC    = 11,
   parameter int unsigned MXKEYB    = 5,
   parameter int unsigned MXPIDB    = 4,
   parameter int unsigned MXDATB    = 9,
   parameter int unsigned LUT_LAT   = 1,
   parameter int unsigned INIT_WAIT = 16
) (
   input  logic                     clock,
   input  logic                     reset_n,
   input  logic                     pause,
   input  logic                     flush,
   input  logic [NREQ-1:0]          req,
   input  logic [NREQ*MXPATC-1:0]   req_carry,
   input  logic [NREQ*MXPIDB-1:0]   req_pid,
   input  logic [NREQ*MXKEYB-1:0]   req_key,
   output logic [NREQ-1:0]          gnt,
   output logic [MXPATC-1:0]        lut_carry0,
   output logic [MXPATC-1:0]        lut_carry1,
   output logic [MXPIDB-1:0]        lut_pid0,
   output logic [MXPIDB-1:0]        lut_pid1,
   input  logic [MXDATB-1:0]        lut_rd0,
   input  logic [MXDATB-1:0]        lut_rd1,
   output logic                     res_vld0,
   output logic                     res_vld1,
   output logic [MXIDB-1:0]         res_id0,
   output logic [MXIDB-1:0]         res_id1,
   output logic [MXKEYB-1:0]        res_key0,
   output logic [MXKEYB-1:0]        res_key1,
   output logic [MXDATB-1:0]        res_data0,
   output logic [MXDATB-1:0]        res_data1,
   output logic                     busy,
   output logic                     ready
);

   localparam int unsigned CNTW = (INIT_WAIT > 1) ? $clog2(INIT_WAIT) : 1;
   localparam int unsigned IDXW = MXIDB + 1;
   localparam int unsigned NST  = LUT_LAT + 1;

   typedef enum logic [1:0] {
      ST_INIT = 2'd0,
      ST_RUN  = 2'd1,
      ST_HOLD = 2'd2
   } state_t;

   state_t                         state_q, state_d;
   logic [CNTW-1:0]                cnt_q, cnt_d;
   logic [MXIDB-1:0]               rr_ptr_q, rr_ptr_d;
   logic                           ready_q, ready_d;
   logic                           busy_q, busy_d;

   logic [1:0][NST-1:0]              vld_q, vld_d;
   logic [1:0][NST-1:0][MXIDB-1:0]   id_q, id_d;
   logic [1:0][NST-1:0][MXKEYB-1:0]  key_q, key_d;
   logic [1:0][MXPATC-1:0]           lut_carry_q, lut_carry_d;
   logic [1:0][MXPIDB-1:0]           lut_pid_q, lut_pid_d;
   logic [1:0]                       res_vld_q, res_vld_d;
   logic [1:0][MXIDB-1:0]            res_id_q, res_id_d;
   logic [1:0][MXKEYB-1:0]           res_key_q, res_key_d;
   logic [1:0][MXDATB-1:0]           res_data_q, res_data_d;

   logic                           grant_en_c;
   logic                           flush_eff_c;
   logic [1:0]                     sel_vld_c;
   logic [1:0][MXIDB-1:0]          sel_idx_c;
   logic [IDXW-1:0]                scan_idx_c;
   logic                           scan_hit_c;
   logic [MXIDB-1:0]               last_idx_c;
   logic [NREQ-1:0]                gnt_c;
   logic [1:0][MXPATC-1:0]         sel_carry_c;
   logic [1:0][MXPIDB-1:0]         sel_pid_c;
   logic [1:0][MXKEYB-1:0]         sel_key_c;
   logic [1:0][MXDATB-1:0]         lut_rd_c;

   assign lut_rd_c    = {lut_rd1, lut_rd0};
   assign grant_en_c  = (state_q == ST_RUN) && !pause && !flush;
   assign flush_eff_c = flush && (state_q != ST_INIT);

   // Circular scan from rr_ptr: first request found takes port 0, second takes port 1.
   always_comb begin
      sel_vld_c  = '0;
      sel_idx_c  = '0;
      scan_idx_c = '0;
      scan_hit_c = 1'b0;
      for (int unsigned k = 0; k < NREQ; k++) begin
         scan_idx_c = IDXW'(rr_ptr_q) + IDXW'(k);
         if (scan_idx_c >= IDXW'(NREQ)) begin
            scan_idx_c = scan_idx_c - IDXW'(NREQ);
         end
         scan_hit_c = 1'b0;
         for (int unsigned i = 0; i < NREQ; i++) begin
            if ((scan_idx_c == IDXW'(i)) && req[i]) begin
               scan_hit_c = 1'b1;
            end
         end
         if (scan_hit_c) begin
            if (!sel_vld_c[0]) begin
               sel_vld_c[0] = 1'b1;
               sel_idx_c[0] = MXIDB'(scan_idx_c);
            end else if (!sel_vld_c[1]) begin
               sel_vld_c[1] = 1'b1;
               sel_idx_c[1] = MXIDB'(scan_idx_c);
            end
         end
      end
   end

   // Payload mux and grant vector for the selected requesters.
   always_comb begin
      sel_carry_c = '0;
      sel_pid_c   = '0;
      sel_key_c   = '0;
      gnt_c       = '0;
      for (int unsigned p = 0; p < 2; p++) begin
         for (int unsigned i = 0; i < NREQ; i++) begin
            if (sel_idx_c[p] == MXIDB'(i)) begin
               sel_carry_c[p] = req_carry[i*MXPATC +: MXPATC];
               sel_pid_c[p]   = req_pid[i*MXPIDB +: MXPIDB];
               sel_key_c[p]   = req_key[i*MXKEYB +: MXKEYB];
               if (grant_en_c && sel_vld_c[p]) begin
                  gnt_c[i] = 1'b1;
               end
            end
         end
      end
   end

   assign gnt = gnt_c;

   // Control FSM, settle counter and round-robin pointer.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      rr_ptr_d   = rr_ptr_q;
      last_idx_c = sel_vld_c[1] ? sel_idx_c[1] : sel_idx_c[0];
      unique case (state_q)
         ST_INIT: begin
            if (cnt_q == CNTW'(INIT_WAIT - 1)) begin
               state_d = ST_RUN;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNTW'(1);
            end
         end
         ST_RUN: begin
            if (pause) begin
               state_d = ST_HOLD;
            end
         end
         ST_HOLD: begin
            if (!pause) begin
               state_d = ST_RUN;
            end
         end
         default: begin
            state_d = ST_INIT;
         end
      endcase
      if (grant_en_c && sel_vld_c[0]) begin
         if ((IDXW'(last_idx_c) + IDXW'(1)) >= IDXW'(NREQ)) begin
            rr_ptr_d = '0;
         end else begin
            rr_ptr_d = last_idx_c + MXIDB'(1);
         end
      end
      ready_d = (state_d == ST_RUN);
   end

   // LUT address stage, tag pipeline and result capture.
   always_comb begin
      vld_d       = vld_q;
      id_d        = id_q;
      key_d       = key_q;
      lut_carry_d = lut_carry_q;
      lut_pid_d   = lut_pid_q;
      res_vld_d   = '0;
      res_id_d    = res_id_q;
      res_key_d   = res_key_q;
      res_data_d  = res_data_q;
      for (int unsigned p = 0; p < 2; p++) begin
         vld_d[p][0] = grant_en_c && sel_vld_c[p];
         id_d[p][0]  = sel_idx_c[p];
         key_d[p][0] = sel_key_c[p];
         for (int unsigned j = 1; j < NST; j++) begin
            vld_d[p][j] = vld_q[p][j-1];
            id_d[p][j]  = id_q[p][j-1];
            key_d[p][j] = key_q[p][j-1];
         end
         res_vld_d[p] = vld_q[p][NST-1] && !flush_eff_c;
         if (vld_q[p][NST-1]) begin
            res_id_d[p]   = id_q[p][NST-1];
            res_key_d[p]  = key_q[p][NST-1];
            res_data_d[p] = lut_rd_c[p];
         end
         if (flush_eff_c) begin
            vld_d[p] = '0;
         end
      end
      // An idle port 1 points at the blank ROM so its output is inert.
      if (grant_en_c && sel_vld_c[0]) begin
         lut_carry_d[0] = sel_carry_c[0];
         lut_pid_d[0]   = sel_pid_c[0];
         if (sel_vld_c[1]) begin
            lut_carry_d[1] = sel_carry_c[1];
            lut_pid_d[1]   = sel_pid_c[1];
         end else begin
            lut_pid_d[1] = {MXPIDB{1'b1}};
         end
      end
      busy_d = |vld_d;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= ST_INIT;
         cnt_q       <= '0;
         rr_ptr_q    <= '0;
         ready_q     <= 1'b0;
         busy_q      <= 1'b0;
         vld_q       <= '0;
         id_q        <= '0;
         key_q       <= '0;
         lut_carry_q <= '0;
         lut_pid_q   <= '0;
         res_vld_q   <= '0;
         res_id_q    <= '0;
         res_key_q   <= '0;
         res_data_q  <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         rr_ptr_q    <= rr_ptr_d;
         ready_q     <= ready_d;
         busy_q      <= busy_d;
         vld_q       <= vld_d;
         id_q        <= id_d;
         key_q       <= key_d;
         lut_carry_q <= lut_carry_d;
         lut_pid_q   <= lut_pid_d;
         res_vld_q   <= res_vld_d;
         res_id_q    <= res_id_d;
         res_key_q   <= res_key_d;
         res_data_q  <= res_data_d;
      end
   end

   assign lut_carry0 = lut_carry_q[0];
   assign lut_carry1 = lut_carry_q[1];
   assign lut_pid0   = lut_pid_q[0];
   assign lut_pid1   = lut_pid_q[1];
   assign res_vld0   = res_vld_q[0];
   assign res_vld1   = res_vld_q[1];
   assign res_id0    = res_id_q[0];
   assign res_id1    = res_id_q[1];
   assign res_key0   = res_key_q[0];
   assign res_key1   = res_key_q[1];
   assign res_data0  = res_data_q[0];
   assign res_data1  = res_data_q[1];
   assign busy       = busy_q;
   assign ready      = ready_q;

endmodule

// File: tb/tb_cclut_lookup_sched.sv
// Bench for cclut_lookup_sched: directed and random requests checked against a
// transaction-level model of arbitration order, result latency, pause and flush.
module tb_cclut_lookup_sched;

   localparam int NREQ    = 4;
   localparam int LUT_LAT = 1;
   localparam int M_INIT  = 0;
   localparam int M_RUN   = 1;
   localparam int M_HOLD  = 2;

   logic          clock;
   logic          reset_n;
   logic          pause;
   logic          flush;
   logic [3:0]    req;
   logic [43:0]   req_carry;
   logic [15:0]   req_pid;
   logic [19:0]   req_key;
   logic [3:0]    gnt;
   logic [10:0]   lut_carry0, lut_carry1;
   logic [3:0]    lut_pid0, lut_pid1;
   logic [8:0]    lut_rd0, lut_rd1;
   logic          res_vld0, res_vld1;
   logic [2:0]    res_id0, res_id1;
   logic [4:0]    res_key0, res_key1;
   logic [8:0]    res_data0, res_data1;
   logic          busy, ready;

   cclut_lookup_sched dut (
      .clock(clock), .reset_n(reset_n), .pause(pause), .flush(flush),
      .req(req), .req_carry(req_carry), .req_pid(req_pid), .req_key(req_key),
      .gnt(gnt), .lut_carry0(lut_carry0), .lut_carry1(lut_carry1),
      .lut_pid0(lut_pid0), .lut_pid1(lut_pid1), .lut_rd0(lut_rd0), .lut_rd1(lut_rd1),
      .res_vld0(res_vld0), .res_vld1(res_vld1), .res_id0(res_id0), .res_id1(res_id1),
      .res_key0(res_key0), .res_key1(res_key1), .res_data0(res_data0),
      .res_data1(res_data1), .busy(busy), .ready(ready)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      int         due;
      int         port;
      int         id;
      logic [4:0] key;
      logic [8:0] data;
   } exp_t;

   exp_t        pq[$];
   int          errors = 0;
   int          checks = 0;
   int          cyc_n  = 0;
   int          m_mode, m_cnt, m_rr;
   logic [10:0] m_lc0, m_lc1;
   logic [3:0]  m_lp0, m_lp1;

   // Pattern ROM stand-in; one address returns a fixed known pattern.
   function automatic logic [8:0] lut_f(input logic [10:0] c, input logic [3:0] p);
      logic [10:0] t;
      if (c == 11'h2A5 && p == 4'd4) return 9'h1C3;
      t = c * 11'd13;
      return t[8:0] ^ {p, 5'd0} ^ 9'h0A5;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_mode = M_INIT; m_cnt = 0; m_rr = 0;
      m_lc0 = '0; m_lc1 = '0; m_lp0 = '0; m_lp1 = '0;
      pq.delete();
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_gnt"},   32'(gnt), 0);
      chk({tag, "_vld0"},  32'(res_vld0), 0);
      chk({tag, "_vld1"},  32'(res_vld1), 0);
      chk({tag, "_busy"},  32'(busy), 0);
      chk({tag, "_ready"}, 32'(ready), 0);
      chk({tag, "_lc0"},   32'(lut_carry0), 0);
      chk({tag, "_lp1"},   32'(lut_pid1), 0);
      chk({tag, "_id1"},   32'(res_id1), 0);
      chk({tag, "_key0"},  32'(res_key0), 0);
      chk({tag, "_dat0"},  32'(res_data0), 0);
   endtask

   task automatic rand_payload();
      req_carry = 44'({$urandom(), $urandom()});
      req_pid   = 16'($urandom());
      req_key   = 20'($urandom());
   endtask

   // One clock: check outputs against the model, run the LUT, advance the model.
   task automatic cyc();
      logic [3:0] eg;
      int         found, i, hit, d;
      int         idx[2];
      bit         grant, eb, ev;
      logic [8:0] nrd0, nrd1;
      exp_t       keep[$];
      exp_t       e;
      #1;
      eg = '0; found = 0; idx[0] = 0; idx[1] = 0;
      grant = (m_mode == M_RUN) && !pause && !flush;
      if (grant) begin
         for (int k = 0; k < NREQ; k++) begin
            i = (m_rr + k) % NREQ;
            if (req[i] && found < 2) begin
               idx[found] = i; found++; eg[i] = 1'b1;
            end
         end
      end
      chk("gnt",   32'(gnt), 32'(eg));
      chk("ready", 32'(ready), 32'(m_mode == M_RUN));
      eb = 1'b0;
      foreach (pq[q]) begin
         d = pq[q].due - cyc_n;
         if (d >= 1 && d <= LUT_LAT + 1) eb = 1'b1;
      end
      chk("busy", 32'(busy), 32'(eb));
      chk("lut_carry0", 32'(lut_carry0), 32'(m_lc0));
      chk("lut_pid0",   32'(lut_pid0),   32'(m_lp0));
      chk("lut_carry1", 32'(lut_carry1), 32'(m_lc1));
      chk("lut_pid1",   32'(lut_pid1),   32'(m_lp1));
      for (int p = 0; p < 2; p++) begin
         hit = -1;
         foreach (pq[q]) if (pq[q].due == cyc_n && pq[q].port == p) hit = q;
         ev = (hit >= 0);
         if (p == 0) begin
            chk("res_vld0", 32'(res_vld0), 32'(ev));
            if (ev) begin
               chk("res_id0",   32'(res_id0),   32'(pq[hit].id));
               chk("res_key0",  32'(res_key0),  32'(pq[hit].key));
               chk("res_data0", 32'(res_data0), 32'(pq[hit].data));
            end
         end else begin
            chk("res_vld1", 32'(res_vld1), 32'(ev));
            if (ev) begin
               chk("res_id1",   32'(res_id1),   32'(pq[hit].id));
               chk("res_key1",  32'(res_key1),  32'(pq[hit].key));
               chk("res_data1", 32'(res_data1), 32'(pq[hit].data));
            end
         end
      end
      nrd0 = lut_f(lut_carry0, lut_pid0);
      nrd1 = lut_f(lut_carry1, lut_pid1);
      // Model update for the end of this cycle.
      foreach (pq[q]) if (pq[q].due > cyc_n) keep.push_back(pq[q]);
      pq = keep;
      if (flush && m_mode != M_INIT) pq.delete();
      for (int p = 0; p < found; p++) begin
         e.due  = cyc_n + LUT_LAT + 2;
         e.port = p;
         e.id   = idx[p];
         e.key  = req_key[idx[p]*5 +: 5];
         e.data = lut_f(req_carry[idx[p]*11 +: 11], req_pid[idx[p]*4 +: 4]);
         pq.push_back(e);
      end
      if (found >= 1) begin
         m_lc0 = req_carry[idx[0]*11 +: 11];
         m_lp0 = req_pid[idx[0]*4 +: 4];
         if (found == 2) begin
            m_lc1 = req_carry[idx[1]*11 +: 11];
            m_lp1 = req_pid[idx[1]*4 +: 4];
         end else begin
            m_lp1 = 4'hF;
         end
         m_rr = (idx[found-1] + 1) % NREQ;
      end
      case (m_mode)
         M_INIT: begin
            if (m_cnt == 15) m_mode = M_RUN;
            else m_cnt++;
         end
         M_RUN:  if (pause) m_mode = M_HOLD;
         default: if (!pause) m_mode = M_RUN;
      endcase
      cyc_n++;
      @(posedge clock);
      #1;
      lut_rd0 = nrd0;
      lut_rd1 = nrd1;
      @(negedge clock);
   endtask

   initial begin
      reset_n = 1'b0; pause = 1'b0; flush = 1'b0; req = '0;
      req_carry = '0; req_pid = '0; req_key = '0; lut_rd0 = '0; lut_rd1 = '0;
      model_reset();
      #1;
      check_zero("reset");
      @(negedge clock);
      @(negedge clock);
      reset_n = 1'b1;

      // Settle period then round robin with all requesters active.
      req = 4'b1111; rand_payload();
      repeat (22) begin cyc(); rand_payload(); end
      req = '0; repeat (4) cyc();

      // Lone requester: port 1 idle and pointed at the blank ROM.
      req = 4'b0100;
      req_carry[22 +: 11] = 11'h2A5; req_pid[8 +: 4] = 4'd4; req_key[10 +: 5] = 5'd17;
      cyc();
      req = '0; repeat (4) cyc();

      // Pause with lookups in flight.
      req = 4'b1111; rand_payload(); cyc();
      pause = 1'b1; repeat (4) cyc();
      pause = 1'b0; repeat (3) cyc();
      req = '0; repeat (4) cyc();

      // Flush one cycle after a grant, then a fresh grant.
      req = 4'b0001; rand_payload(); cyc();
      req = '0; flush = 1'b1; cyc();
      flush = 1'b0; req = 4'b0010; rand_payload(); cyc();
      req = '0; repeat (5) cyc();

      // Random traffic with occasional pause and flush.
      repeat (400) begin
         req   = 4'($urandom());
         pause = ($urandom_range(0, 9) == 0);
         flush = ($urandom_range(0, 19) == 0);
         rand_payload();
         cyc();
      end
      pause = 1'b0; flush = 1'b0;
      req = 4'b1111; rand_payload(); repeat (3) cyc();

      // Asynchronous reset while lookups are in flight.
      req = 4'b1111; rand_payload(); cyc();
      req = '0;
      reset_n = 1'b0;
      #1;
      check_zero("midrst");
      model_reset();
      @(negedge clock);
      reset_n = 1'b1;
      req = 4'b1111;
      repeat (22) begin cyc(); rand_payload(); end
      req = '0; repeat (5) cyc();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
